instr_queue: RTL

- Circular FIFO between the instruction fetcher and the decoder.
- Buffers fetched {pc, instr} pairs and presents the head entry combinationally to the decoder as pc/instr plus an is_empty flag.
- Pops one entry per cycle unless issue is stalled.
- Flushed wholesale on a ROB mispredict clear.

---
 rtl/instr_queue_pkg.sv | 19 +
 rtl/instr_queue_mem.sv | 35 +++
 rtl/instr_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: shared sizing and entry type for the fetch-to-decode
// instruction queue.
//   PcLength / InstrLength : MSB index of the pc and instruction words
//   IqDepth / IqPtrLength  : queue depth and MSB index of its pointers, shared
//                            so the fetcher and the top level agree on sizing
//   iq_entry_t             : one buffered {pc, instr} pair
package instr_queue_pkg;

  localparam int unsigned PcLength    = 31;
  localparam int unsigned InstrLength = 31;
  localparam int unsigned IqDepth     = 16;
  localparam int unsigned IqPtrLength = 3;

  typedef struct packed {
    logic [PcLength:0]    pc;
    logic [InstrLength:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_mem.sv
// instr_queue_mem: storage array for the instruction queue.
// One synchronous write port and one asynchronous read port.
// Contents are not reset; the pointer/count logic decides which entries are
// valid.
//   clk   : system clock
//   we    : write enable
//   waddr : write address (tail)
//   wdata : {pc, instr} entry to store
//   raddr : read address (head)
//   rdata : entry at raddr, combinational
module instr_queue_mem
  import instr_queue_pkg::*;
#(
  parameter int unsigned Depth     = IqDepth,
  parameter int unsigned AddrWidth = IqPtrLength + 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  iq_entry_t            wdata,
  input  logic [AddrWidth-1:0] raddr,
  output iq_entry_t            rdata
);

  iq_entry_t mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between the instruction fetcher and the decoder.
// Buffers {pc, instr} pairs and presents the head combinationally to the
// decoder. Pops one entry per cycle unless issue stalls; a ROB clear flushes
// everything. Optional macro IQ_BYPASS_EN lets an entry offered to an empty
// queue reach the decoder in the same cycle.
//   clk                 : system clock, rising edge
//   rst                 : asynchronous reset, active-low
//   is_valid_from_if    : fetcher offers an entry
//   pc_from_if          : pc of the offered entry
//   instr_from_if       : instruction word of the offered entry
//   is_full_to_if       : queue holds QueueDepth entries
//   is_stall_from_issue : issue cannot accept; head is held
//   is_clear_from_rob   : mispredict flush
//   is_empty_to_dc      : no valid head entry
//   pc_to_dc            : head pc, 0 when empty
//   instr_to_dc         : head instruction, 0 when empty
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int unsigned QueueDepth = IqDepth,
  parameter int unsigned PtrLength  = IqPtrLength
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_valid_from_if,
  input  logic [PcLength:0]    pc_from_if,
  input  logic [InstrLength:0] instr_from_if,
  output logic                 is_full_to_if,
  input  logic                 is_stall_from_issue,
  input  logic                 is_clear_from_rob,
  output logic                 is_empty_to_dc,
  output logic [PcLength:0]    pc_to_dc,
  output logic [InstrLength:0] instr_to_dc
);

  localparam logic [PtrLength+1:0] FullCount = (PtrLength + 2)'(QueueDepth);

  logic [PtrLength:0]   head;
  logic [PtrLength:0]   tail;
  logic [PtrLength+1:0] count;

  logic      stored_empty;
  logic      bypass;
  logic      push;
  logic      pop;
  iq_entry_t wr_entry;
  iq_entry_t head_entry;

  assign stored_empty  = (count == '0);
  assign is_full_to_if = (count == FullCount);

`ifdef IQ_BYPASS_EN
  assign bypass = stored_empty && is_valid_from_if && !is_clear_from_rob;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by an unstalled decoder is never stored.
  assign push = is_valid_from_if && !is_full_to_if && !(bypass && !is_stall_from_issue);
  assign pop  = !stored_empty && !is_stall_from_issue;

  assign wr_entry = '{pc: pc_from_if, instr: instr_from_if};

  instr_queue_mem #(
    .Depth     (QueueDepth),
    .AddrWidth (PtrLength + 1)
  ) u_mem (
    .clk   (clk),
    .we    (push && !is_clear_from_rob),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  // Pointers wrap naturally: QueueDepth is a power of two equal to 2**(PtrLength+1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (is_clear_from_rob) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    is_empty_to_dc = stored_empty && !bypass;
    pc_to_dc       = '0;
    instr_to_dc    = '0;
    if (bypass) begin
      pc_to_dc    = pc_from_if;
      instr_to_dc = instr_from_if;
    end else if (!stored_empty) begin
      pc_to_dc    = head_entry.pc;
      instr_to_dc = head_entry.instr;
    end
  end

endmodule
